pic_host_sequencer: RTL and testbench

PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

---
 rtl/pic_host_sequencer.sv | 119 +++++++++++
 tb/tb_pic_host_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC bus: turns single register read/write
// commands into CS_n/RD_n/WR_n cycles and auto-runs the two-pulse INTA_n acknowledge.
module pic_host_sequencer #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_en,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       INT,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       INTA_n,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, ACK2} state_t;

    localparam logic [3:0] STB_LD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_ld;
    logic       run_q, ack_q, rd_q, a0_q;
    logic [7:0] wdat_q, rsp_q, vec_q;
    logic       ack_start, accept, last;

    // run_q holds cmd_ready low until the first edge after reset releases
    assign ack_start = (state == IDLE) && INT && int_en;
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (cnt == 4'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            run_q  <= 1'b0;
            ack_q  <= 1'b0;
            rd_q   <= 1'b0;
            a0_q   <= 1'b0;
            wdat_q <= 8'd0;
            rsp_q  <= 8'd0;
            vec_q  <= 8'd0;
        end else begin
            run_q <= 1'b1;
            state <= state_nxt;
            if (state_nxt != state) cnt <= cnt_ld;
            else if (!last)         cnt <= cnt - 4'd1;
            if (ack_start) begin
                ack_q <= 1'b1;
            end else if (accept) begin
                ack_q  <= 1'b0;
                rd_q   <= cmd_rd;
                a0_q   <= cmd_a0;
                wdat_q <= cmd_data;
            end
            if (state == STROBE && last && !ack_q && rd_q) rsp_q <= D_in;
            // only the second acknowledge pulse carries the vector
            if (state == ACK2 && last) vec_q <= D_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_ld    = 4'd0;
        case (state)
            IDLE:    if (ack_start)   state_nxt = STROBE;
                     else if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (last) state_nxt = ack_q ? GAP : HOLD;
            GAP:     if (last) state_nxt = ACK2;
            ACK2:    if (last) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        case (state_nxt)
            STROBE, ACK2: cnt_ld = STB_LD;
            GAP:          cnt_ld = GAP_LD;
            default:      cnt_ld = 4'd0;
        endcase
    end

    always_comb begin
        cmd_ready = run_q && (state == IDLE) && !ack_start;
        CS_n      = 1'b1;
        RD_n      = 1'b1;
        WR_n      = 1'b1;
        INTA_n    = 1'b1;
        D_oe      = 1'b0;
        rsp_valid = 1'b0;
        vec_valid = 1'b0;
        A0        = a0_q;
        D_out     = wdat_q;
        rsp_data  = rsp_q;
        vec_data  = vec_q;
        if (ack_q) begin
            INTA_n    = !(state == STROBE || state == ACK2);
            vec_valid = (state == HOLD);
        end else if (state == SETUP || state == STROBE || state == HOLD) begin
            CS_n      = 1'b0;
            RD_n      = !(rd_q && state == STROBE);
            WR_n      = !(!rd_q && state == STROBE);
            D_oe      = !rd_q;
            rsp_valid = rd_q && (state == HOLD);
        end
    end
endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: per-cycle strobe traces checked against
// hand-built bit patterns (bit i = signal level in cycle i of the watch window).
module tb_pic_host_sequencer;
    logic       CLK = 1'b0, RST = 1'b1;
    logic       cmd_valid = 0, cmd_ready, cmd_rd = 0, cmd_a0 = 0;
    logic [7:0] cmd_data = 0, rsp_data, vec_data, D_out, D_in = 0;
    logic       rsp_valid, int_en = 0, vec_valid, INT = 0;
    logic       CS_n, RD_n, WR_n, INTA_n, A0, D_oe;

    int n_cmp = 0, n_bad = 0;

    logic [31:0] cs_seq, rd_seq, wr_seq, inta_seq, oe_seq, rsp_seq, vec_seq;
    int          ready_cnt, rsp_cnt, vec_cnt, a0_bad, dout_bad, ovl;
    logic [7:0]  rsp_last, vec_last, exp_dout;
    logic        exp_a0;

    pic_host_sequencer dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .int_en(int_en),
        .vec_valid(vec_valid), .vec_data(vec_data), .INT(INT),
        .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .INTA_n(INTA_n), .A0(A0),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples n cycles on the falling edge; optionally drops INT / switches D_in
    // after sampling cycle int_drop / dsw_at, and retires cmd_valid on handshake.
    task automatic watch(input int n, input int int_drop, input int dsw_at, input logic [7:0] dsw_val);
        cs_seq = '0; rd_seq = '0; wr_seq = '0; inta_seq = '0; oe_seq = '0;
        rsp_seq = '0; vec_seq = '0;
        ready_cnt = 0; rsp_cnt = 0; vec_cnt = 0; a0_bad = 0; dout_bad = 0; ovl = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cs_seq[i] = CS_n; rd_seq[i] = RD_n; wr_seq[i] = WR_n;
            inta_seq[i] = INTA_n; oe_seq[i] = D_oe;
            if (!CS_n && A0 !== exp_a0) a0_bad++;
            if (D_oe && D_out !== exp_dout) dout_bad++;
            if ((RD_n ? 0 : 1) + (WR_n ? 0 : 1) + (INTA_n ? 0 : 1) > 1) ovl++;
            if (cmd_ready) ready_cnt++;
            if (rsp_valid) begin rsp_seq[i] = 1'b1; rsp_cnt++; rsp_last = rsp_data; end
            if (vec_valid) begin vec_seq[i] = 1'b1; vec_cnt++; vec_last = vec_data; end
            if (i == int_drop) INT = 1'b0;
            if (i == dsw_at) D_in = dsw_val;
            if (cmd_valid && cmd_ready) begin
                @(posedge CLK);
                #1 cmd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #3;
        chk("rst_strobes", {28'd0, CS_n, RD_n, WR_n, INTA_n}, 32'hF);
        chk("rst_misc", {26'd0, A0, D_oe, cmd_ready, rsp_valid, vec_valid, 1'b0}, 32'h0);
        chk("rst_data", {8'd0, D_out, rsp_data, vec_data}, 32'h0);
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1 chk("ready_before_edge", cmd_ready, 0);
        @(posedge CLK); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // write a0=0 data=0x13
        exp_a0 = 0; exp_dout = 8'h13;
        cmd_valid = 1; cmd_rd = 0; cmd_a0 = 0; cmd_data = 8'h13;
        watch(12, -1, -1, 8'h00);
        chk("wr_cs", cs_seq, 32'hFE1);
        chk("wr_wr", wr_seq, 32'hFF3);
        chk("wr_rd", rd_seq, 32'hFFF);
        chk("wr_oe", oe_seq, 32'h01E);
        chk("wr_dout", dout_bad, 0);
        chk("wr_a0", a0_bad, 0);
        chk("wr_rsp", rsp_cnt, 0);
        chk("wr_ready", ready_cnt, 8);

        // read a0=1, D_in=0xA5
        @(posedge CLK); #1;
        exp_a0 = 1; D_in = 8'hA5;
        cmd_valid = 1; cmd_rd = 1; cmd_a0 = 1; cmd_data = 8'h00;
        watch(12, -1, -1, 8'h00);
        chk("rd_cs", cs_seq, 32'hFE1);
        chk("rd_rd", rd_seq, 32'hFF3);
        chk("rd_wr", wr_seq, 32'hFFF);
        chk("rd_oe", oe_seq, 32'h0);
        chk("rd_a0", a0_bad, 0);
        chk("rd_rsp_seq", rsp_seq, 32'h010);
        chk("rd_rsp_data", rsp_last, 8'hA5);

        // acknowledge: 0xFF on pulse 1, 0x4B only on the last ACK2 cycle
        @(posedge CLK); #1;
        D_in = 8'hFF; INT = 1; int_en = 1;
        watch(12, 1, 6, 8'h4B);
        chk("ack_inta", inta_seq, 32'hF99);
        chk("ack_cs", cs_seq, 32'hFFF);
        chk("ack_rdwr", rd_seq & wr_seq, 32'hFFF);
        chk("ack_oe", oe_seq, 32'h0);
        chk("ack_vec_seq", vec_seq, 32'h080);
        chk("ack_vec_data", vec_last, 8'h4B);
        chk("ack_ready", ready_cnt, 4);
        chk("rsp_hold", rsp_data, 8'hA5);

        // INT drops during GAP: second pulse still happens
        @(posedge CLK); #1;
        D_in = 8'hFF; INT = 1;
        watch(12, 3, 6, 8'h5A);
        chk("gap_inta", inta_seq, 32'hF99);
        chk("gap_vec_cnt", vec_cnt, 1);
        chk("gap_vec_data", vec_data, 8'h5A);

        // INT and a write arrive together: ack first, write afterward
        @(posedge CLK); #1;
        D_in = 8'hFF; INT = 1; exp_a0 = 1; exp_dout = 8'h3C;
        cmd_valid = 1; cmd_rd = 0; cmd_a0 = 1; cmd_data = 8'h3C;
        watch(20, 1, 6, 8'h77);
        chk("race_inta", inta_seq, 32'hFFF99);
        chk("race_cs", cs_seq, 32'hFE1FF);
        chk("race_wr", wr_seq, 32'hFF3FF);
        chk("race_vec", vec_last, 8'h77);
        chk("race_ready", ready_cnt, 8);
        chk("race_a0_dout", a0_bad + dout_bad, 0);
        chk("race_rsp", rsp_cnt, 0);

        // reset during ACK2 aborts the acknowledge
        @(posedge CLK); #1;
        D_in = 8'hFF; INT = 1;
        repeat (5) @(posedge CLK);
        #1 INT = 0;
        #2 RST = 1;
        #1 chk("abort_inta", INTA_n, 1);
        chk("abort_vec_valid", vec_valid, 0);
        chk("abort_vec_data", vec_data, 8'h00);
        @(posedge CLK); @(negedge CLK);
        RST = 0;
        #1 chk("abort_ready_pre", cmd_ready, 0);
        @(posedge CLK); #1;
        chk("abort_ready_post", cmd_ready, 1);
        watch(6, -1, -1, 8'h00);
        chk("abort_no_vec", vec_cnt + rsp_cnt, 0);
        chk("overlap", ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
